// File: rtl/capture_pkg.sv
// Shared types for the capture framer: sample word layout, FIFO entry and framer states.
// Pure declarations; no logic of its own.
package capture_pkg;

  localparam int TS_WIDTH     = 49;
  localparam int SAMPLE_WIDTH = 15;
  localparam int WORD_WIDTH   = TS_WIDTH + SAMPLE_WIDTH;

  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/capture_framer_if.sv
// Stream bundle of the framer: ready-less ADC input and AXI-Stream output with tlast.
// The slave side is the framer; the master side is the ADC source plus the stream sink.
interface capture_framer_if;
  import capture_pkg::*;

  logic                  s_axis_tvalid;
  logic [WORD_WIDTH-1:0] s_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [WORD_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output m_axis_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tlast
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  m_axis_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tlast
  );

endinterface

// File: rtl/capture_framer_sync_fifo.sv
// Single-clock show-ahead FIFO on a synchronous-read RAM; a write reaches the head one edge later.
// Push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH      = 65,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_dat,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    rd_q;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] rd_addr;
  logic                head_vld;
  logic                push_ok;
  logic                pop_ok;

  assign pop_ok  = pop && head_vld;
  assign push_ok = push && (!full || pop_ok);

  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = !head_vld;

  // Read one slot ahead while popping so the next head is ready the cycle after the pop.
  assign rd_addr = rd_ptr + {{ADDR_WIDTH{1'b0}}, pop_ok};

  assign pop_dat = head_vld ? rd_q : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_dat;
    end
    rd_q <= mem[rd_addr[ADDR_WIDTH-1:0]];
  end

  // The head is valid once the slot being read was written before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_addr;
      head_vld <= (rd_addr != wr_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/capture_framer.sv
// Buffers the ready-less ADC stream and re-emits it as AXI-Stream frames with tlast.
// Two edges from input to FIFO head; output stalls are absorbed by the FIFO, input drops on full.
module capture_framer
  import capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 256
) (
  input  logic                aclk,
  input  logic                areset,
  capture_framer_if.slave     stream,
  input  logic                clear_status,
  output logic [ADDR_WIDTH:0] fifo_count,
  output logic [31:0]         frame_count,
  output logic [31:0]         drop_count,
  output logic                overflow
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] pend_dat;
  logic [15:0]           word_idx;
  logic [15:0]           word_idx_nxt;
  logic                  push;
  logic                  push_last;
  logic                  push_ok;
  logic                  drop;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  fifo_entry_t           wr_entry;
  fifo_entry_t           rd_entry;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending word needs no reset: it is only consumed while in HOLD.
  always_ff @(posedge aclk) begin
    if (stream.s_axis_tvalid) begin
      pend_dat <= stream.s_axis_tdata;
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_last = 1'b0;
    case (state)
      IDLE: begin
        if (stream.s_axis_tvalid) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        push      = 1'b1;
        push_last = !stream.s_axis_tvalid || (word_idx == LAST_IDX);
        if (!stream.s_axis_tvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop     = !fifo_empty && stream.m_axis_tready;
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && !push_ok;

  // A dropped last word still closes the frame so the next one starts aligned.
  always_comb begin
    word_idx_nxt = word_idx;
    if (push && push_last) begin
      word_idx_nxt = '0;
    end else if (push_ok) begin
      word_idx_nxt = word_idx + 16'd1;
    end
  end

  always_comb begin
    wr_entry.last = push_last;
    wr_entry.data = pend_dat;
  end

  sync_fifo #(
    .WIDTH      ($bits(fifo_entry_t)),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (push_ok),
    .push_dat (wr_entry),
    .pop      (pop),
    .pop_dat  (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign stream.m_axis_tvalid = !fifo_empty;
  assign stream.m_axis_tdata  = rd_entry.data;
  assign stream.m_axis_tlast  = rd_entry.last;

  always_ff @(posedge aclk) begin
    if (areset) begin
      word_idx <= '0;
    end else begin
      word_idx <= word_idx_nxt;
    end
  end

  // Clear takes priority over a drop or frame end in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset || clear_status) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok && push_last) begin
        frame_count <= frame_count + 32'd1;
      end
      if (drop) begin
        drop_count <= sat_inc32(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_framer.sv
// Directed bench for capture_framer: three instances cover default, small-FIFO and short-frame setups.
module tb_capture_framer;
  import capture_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset;
  logic        s_vld;
  logic [63:0] s_dat;
  logic        rdy_a, rdy_b, rdy_c;
  logic        clr_a, clr_b, clr_c;

  logic [10:0] fc_a;
  logic [4:0]  fc_b, fc_c;
  logic [31:0] frm_a, frm_b, frm_c;
  logic [31:0] drp_a, drp_b, drp_c;
  logic        ovf_a, ovf_b, ovf_c;

  capture_framer_if if_a ();
  capture_framer_if if_b ();
  capture_framer_if if_c ();

  assign if_a.s_axis_tvalid = s_vld;
  assign if_a.s_axis_tdata  = s_dat;
  assign if_a.m_axis_tready = rdy_a;
  assign if_b.s_axis_tvalid = s_vld;
  assign if_b.s_axis_tdata  = s_dat;
  assign if_b.m_axis_tready = rdy_b;
  assign if_c.s_axis_tvalid = s_vld;
  assign if_c.s_axis_tdata  = s_dat;
  assign if_c.m_axis_tready = rdy_c;

  capture_framer #(.ADDR_WIDTH(10), .FRAME_LEN(256)) dut_a (
    .aclk(aclk), .areset(areset), .stream(if_a), .clear_status(clr_a),
    .fifo_count(fc_a), .frame_count(frm_a), .drop_count(drp_a), .overflow(ovf_a)
  );

  capture_framer #(.ADDR_WIDTH(4), .FRAME_LEN(256)) dut_b (
    .aclk(aclk), .areset(areset), .stream(if_b), .clear_status(clr_b),
    .fifo_count(fc_b), .frame_count(frm_b), .drop_count(drp_b), .overflow(ovf_b)
  );

  capture_framer #(.ADDR_WIDTH(4), .FRAME_LEN(8)) dut_c (
    .aclk(aclk), .areset(areset), .stream(if_c), .clear_status(clr_c),
    .fifo_count(fc_c), .frame_count(frm_c), .drop_count(drp_c), .overflow(ovf_c)
  );

  int checks = 0;
  int errors = 0;

  logic [64:0] q_a[$];
  logic [64:0] q_b[$];
  logic [64:0] q_c[$];

  // Accepted output beats, sampled mid-cycle ahead of the edge that pops them.
  always @(negedge aclk) begin
    if (if_a.m_axis_tvalid && if_a.m_axis_tready) q_a.push_back({if_a.m_axis_tlast, if_a.m_axis_tdata});
    if (if_b.m_axis_tvalid && if_b.m_axis_tready) q_b.push_back({if_b.m_axis_tlast, if_b.m_axis_tdata});
    if (if_c.m_axis_tvalid && if_c.m_axis_tready) q_c.push_back({if_c.m_axis_tlast, if_c.m_axis_tdata});
  end

  function automatic logic [63:0] w(input int i);
    return {49'(i + 1000), 15'((i * 7) & 32767)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_vld  = 1'b0;
    repeat (2) tick();
    areset = 1'b0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  task automatic burst(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      s_vld = 1'b1;
      s_dat = w(start + i);
      tick();
    end
    s_vld = 1'b0;
    s_dat = '0;
  endtask

  task automatic check_q(input string tag, input logic [64:0] q[$], input int start, input int n,
                         input int l0, input int l1, input int l2);
    int dbad = 0;
    int lbad = 0;
    check({tag, "_len"}, 64'(q.size()), 64'(n));
    for (int j = 0; j < q.size() && j < n; j++) begin
      if (q[j][63:0] !== w(start + j)) dbad++;
      if (q[j][64] !== ((j == l0) || (j == l1) || (j == l2))) lbad++;
    end
    check({tag, "_data_errs"}, 64'(dbad), 64'd0);
    check({tag, "_last_errs"}, 64'(lbad), 64'd0);
  endtask

  initial begin
    int bad;
    areset = 1'b1;
    s_vld  = 1'b0;
    s_dat  = '0;
    rdy_a  = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    clr_a  = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (3) tick();
    areset = 1'b0;

    check("rst_tvalid", 64'(if_a.m_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(if_a.m_axis_tlast),  64'd0);
    check("rst_tdata",  if_a.m_axis_tdata,       64'd0);
    check("rst_count",  64'(fc_a),  64'd0);
    check("rst_frames", 64'(frm_a), 64'd0);
    check("rst_drops",  64'(drp_a), 64'd0);
    check("rst_ovf",    64'(ovf_a), 64'd0);

    // Single 5-word burst, latency of the first word.
    rdy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_vld = 1'b1;
      s_dat = w(i);
      tick();
      if (i == 1) check("t1_vld_k1", 64'(if_a.m_axis_tvalid), 64'd0);
      if (i == 2) begin
        check("t1_vld_k2",  64'(if_a.m_axis_tvalid), 64'd1);
        check("t1_data_k2", if_a.m_axis_tdata, w(0));
      end
    end
    s_vld = 1'b0;
    repeat (10) tick();
    check_q("t1", q_a, 0, 5, 4, -1, -1);
    check("t1_frames", 64'(frm_a), 64'd1);
    check("t1_drops",  64'(drp_a), 64'd0);

    // 600-word burst split at 256 and 512.
    do_reset();
    rdy_a = 1'b1;
    burst(0, 600);
    repeat (10) tick();
    check_q("t2", q_a, 0, 600, 255, 511, 599);
    check("t2_frames", 64'(frm_a), 64'd3);
    check("t2_drops",  64'(drp_a), 64'd0);

    // Overflow of a 16-deep FIFO with the sink stalled.
    do_reset();
    rdy_b = 1'b0;
    burst(0, 20);
    repeat (3) tick();
    check("t3_count",  64'(fc_b),  64'd16);
    check("t3_drops",  64'(drp_b), 64'd4);
    check("t3_ovf",    64'(ovf_b), 64'd1);
    check("t3_frames", 64'(frm_b), 64'd0);
    check("t3_hold_vld",  64'(if_b.m_axis_tvalid), 64'd1);
    check("t3_hold_data", if_b.m_axis_tdata, w(0));
    rdy_b = 1'b1;
    repeat (20) tick();
    check_q("t3", q_b, 0, 16, -1, -1, -1);
    check("t3_frames_end", 64'(frm_b), 64'd0);
    check("t3_count_end",  64'(fc_b),  64'd0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    rdy_b = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_vld = 1'b1;
      s_dat = w(i);
      tick();
    end
    check("t4_full", 64'(fc_b), 64'd16);
    rdy_b = 1'b1;
    bad = 0;
    for (int i = 17; i < 47; i++) begin
      s_dat = w(i);
      tick();
      if (fc_b != 5'd16) bad++;
    end
    check("t4_count_held", 64'(bad), 64'd0);
    check("t4_drops", 64'(drp_b), 64'd0);
    s_vld = 1'b0;
    repeat (25) tick();
    check_q("t4", q_b, 0, 47, 46, -1, -1);
    check("t4_frames", 64'(frm_b), 64'd1);
    check("t4_ovf",    64'(ovf_b), 64'd0);

    // Burst length equal to the frame length, then clear against a drop.
    do_reset();
    rdy_c = 1'b1;
    burst(0, 8);
    repeat (8) tick();
    check_q("t5", q_c, 0, 8, 7, -1, -1);
    check("t5_frames", 64'(frm_c), 64'd1);
    rdy_c = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_vld = 1'b1;
      s_dat = w(100 + i);
      tick();
    end
    s_vld = 1'b0;
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    check("t5_clr_drops",  64'(drp_c), 64'd0);
    check("t5_clr_ovf",    64'(ovf_c), 64'd0);
    check("t5_clr_frames", 64'(frm_c), 64'd0);
    check("t5_count",      64'(fc_c),  64'd16);

    // Reset with a frame in flight.
    do_reset();
    rdy_a = 1'b0;
    burst(0, 4);
    check("t6_queued", 64'(fc_a), 64'd3);
    areset = 1'b1;
    tick();
    check("t6_tvalid", 64'(if_a.m_axis_tvalid), 64'd0);
    check("t6_tlast",  64'(if_a.m_axis_tlast),  64'd0);
    check("t6_tdata",  if_a.m_axis_tdata,       64'd0);
    check("t6_count",  64'(fc_a),  64'd0);
    check("t6_frames", 64'(frm_a), 64'd0);
    check("t6_drops",  64'(drp_a), 64'd0);
    check("t6_ovf",    64'(ovf_a), 64'd0);
    areset = 1'b0;
    q_a.delete();
    rdy_a = 1'b1;
    tick();
    burst(200, 2);
    repeat (8) tick();
    check_q("t6", q_a, 200, 2, 1, -1, -1);
    check("t6_frames_end", 64'(frm_a), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_framer.md
# capture_framer

Downstream stage of the ADC trigger block. It takes that block's 64-bit sample stream, which carries a valid signal but no ready, and buffers it in an on-chip FIFO. It re-emits the stream as AXI-Stream with backpressure and `tlast`, cutting it into frames of at most `FRAME_LEN` words or at the end of a trigger burst. It sits between the ADC core and the DMA/stream writer, and reports occupancy, frame and drop statistics to the status registers.

## Interface

**Parameters**
- `ADDR_WIDTH`, 10: FIFO depth is 2^ADDR_WIDTH words.
- `FRAME_LEN`, 256: maximum words per frame. Range 1 .. 65535.

**Ports**
- `aclk` in 1: sole clock.
- `areset` in 1: reset, synchronous and active-high.
- `s_axis_tvalid` in 1: input word valid. There is no ready; the upstream stage cannot be stalled.
- `s_axis_tdata` in 64: {timestamp[48:0], sample[14:0]}, passed through unmodified.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out 64: output word.
- `m_axis_tlast` out 1: last word of a frame.
- `clear_status` in 1: single-cycle pulse; clears `drop_count`, `overflow` and `frame_count`.
- `fifo_count` out ADDR_WIDTH+1: current FIFO occupancy.
- `frame_count` out 32: frames written into the FIFO, wrapping.
- `drop_count` out 32: words dropped on full FIFO, saturating at 0xFFFFFFFF.
- `overflow` out 1: sticky, set by any drop.

## Operation

**Pending register.** Each valid input word is held one cycle in a pending register, so its `last` bit is known before it is written to the FIFO.

**Framer FSM.**
- IDLE (no pending word):
  - `s_axis_tvalid=1`: load pending, go to HOLD.
- HOLD (pending word held): each cycle the pending word is pushed with a `last` bit.
  - `last=1` if `s_axis_tvalid=0` (end of burst) or `word_idx==FRAME_LEN-1`; otherwise `last=0`.
  - If both conditions are true at once, the word gets a single `last=1`.
  - `s_axis_tvalid=1`: the new word is loaded into pending in the same cycle; stay in HOLD.
  - `s_axis_tvalid=0`: go to IDLE.

**Word index.** `word_idx` counts words successfully pushed in the current frame. It is cleared after a pushed `last=1` word.

**Push arbitration.**
- A push is accepted if `fifo_count<DEPTH`, or if a pop occurs in the same cycle.
- Otherwise the word is dropped:
  - `drop_count` increments (saturating) and `overflow` sets.
  - `word_idx` is unchanged.
- If the dropped word carried `last=1`, `word_idx` still clears and `frame_count` does not increment. That frame loses its `tlast`; consumers resynchronise on timestamps.

**Frame counting.** `frame_count` increments on each accepted push with `last=1`.

**FIFO.**
- Stores 65 bits per entry: {last, data}.
- Show-ahead read: `m_axis_tvalid = !empty`, and `tdata`/`tlast` come from the head entry.
- Pop when `m_axis_tvalid && m_axis_tready`.
- Read and write pointers are ADDR_WIDTH+1 bits and wrap naturally. Full and empty are decoded from the pointer MSB.

**Clear vs. drop.** If `clear_status` coincides with a drop, clear wins: counters read 0 and `overflow` reads 0 after the edge.

**Reset.**
- `areset` overrides everything:
  - pointers, `fifo_count`, the counters, `overflow` and `word_idx` go to 0;
  - the FSM goes to IDLE and the pending word is discarded.
- A frame in flight at reset is lost entirely.

## Timing

**Reset values.** All outputs are 0 after reset: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `fifo_count`, `frame_count`, `drop_count`, `overflow`.

**Latency.**
- Word sampled at edge k is pushed at edge k+1.
- It is visible at the FIFO head, with `m_axis_tvalid=1`, in the cycle after edge k+2, provided the FIFO was empty.

**Throughput.** One word per cycle sustained on both ports.

**Handshake.** While `m_axis_tvalid=1` and `m_axis_tready=0`, `tdata` and `tlast` hold stable. A deassertion of `m_axis_tready` never drops data; the FIFO absorbs the stall.

**Occupancy.** `fifo_count` is registered and reflects pushes and pops of the previous edge. A simultaneous push and pop leaves it unchanged.

**Status.** All status outputs are registered and update one edge after the event.

## Structure

**Package `capture_pkg`:**
- `TS_WIDTH=49`, `SAMPLE_WIDTH=15`, `WORD_WIDTH=64`;
- the packed struct `fifo_entry_t` {last, data[63:0]};
- the FSM state enum {IDLE, HOLD}.

**Sub-module `sync_fifo`:** a single-clock show-ahead FIFO, parameterised by width and ADDR_WIDTH, with push/pop/full/empty/count. It should infer block RAM with an output register bypass. The framer FSM, counters and status logic stay in `capture_framer`.

## Test plan

1. **Single burst.** Burst of 5 valid words, `FRAME_LEN=256`, `m_axis_tready=1` → 5 output words in order, `tlast` only on word 5, `frame_count=1`, first output 2 cycles after edge of first input.
2. **Frame splitting.** Continuous burst of 600 words, `FRAME_LEN=256`, `tready=1` → `tlast` on words 256, 512 and 600, `frame_count=3`, `drop_count=0`.
3. **Overflow.** `ADDR_WIDTH=4` (depth 16), `tready=0`, burst of 20 words → `fifo_count=16`, `drop_count=4`, `overflow=1`. Then `tready=1` → the first 16 words drain intact; the dropped final word's `tlast` is absent and `frame_count=0`.
4. **Push on full with pop.** FIFO full with `tready=1` and continuous input → push and pop in the same cycle, no drops, `fifo_count` stays 16.
5. **Frame end meets burst end.** Burst length exactly `FRAME_LEN=8` → a single `tlast` on word 8, `frame_count=1`. Then `clear_status` in the same cycle as a drop → `drop_count=0`, `overflow=0`.
6. **Reset mid-frame.** `areset` pulsed mid-burst with 3 words queued → all outputs 0 next cycle; a subsequent 2-word burst emits exactly 2 words with `tlast` on the second.
